// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: register ids, scoreboard sizing and id decode helpers.
package reg_scoreboard_pkg;
   typedef enum logic [7:0] {
      rnil = 8'h00,
      rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi,
      r8, r9, r10, r11, r12, r13, r14, r15,
      rflags, rha, rhb, rhc,
      rip, rimm, rsyscall, rv0, rv8
   } reg_id_t;
   localparam int REG_FILE_SIZE = 20;
   localparam int MAX_PENDING = 3;
   localparam int PEND_W = $clog2(MAX_PENDING + 1);
   typedef logic [PEND_W-1:0] pend_cnt_t;
   typedef logic [$clog2(REG_FILE_SIZE)-1:0] reg_idx_t;
   function automatic logic reg_in_file(reg_id_t id);
      return id >= rax && id <= rhc;
   endfunction
   function automatic reg_idx_t reg_num(reg_id_t id);
      logic [7:0] d;
      d = 8'(id) - 8'(rax);
      return reg_idx_t'(d);
   endfunction
   // One-hot select of a tracked register; untracked ids select nothing.
   function automatic logic [REG_FILE_SIZE-1:0] reg_onehot(reg_id_t id);
      return reg_in_file(id) ? {{(REG_FILE_SIZE-1){1'b0}}, 1'b1} << reg_num(id) : '0;
   endfunction
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: issue, writeback and status signals of the scoreboard.
//   flush, iss_* : issue request / handshake and flush from decode
//   wb0_*, wb1_* : writeback strobes from the two result ports
//   busy_vec, outstanding, err_underflow : registered scoreboard status
interface reg_scoreboard_if;
   import reg_scoreboard_pkg::*;
   logic flush;
   logic iss_valid;
   logic iss_ready;
   reg_id_t iss_src0;
   reg_id_t iss_src1;
   reg_id_t iss_dst0;
   reg_id_t iss_dst1;
   logic wb0_valid;
   reg_id_t wb0_reg;
   logic wb1_valid;
   reg_id_t wb1_reg;
   logic [REG_FILE_SIZE-1:0] busy_vec;
   logic [7:0] outstanding;
   logic err_underflow;
   modport master (
      output flush, iss_valid, iss_src0, iss_src1, iss_dst0, iss_dst1,
             wb0_valid, wb0_reg, wb1_valid, wb1_reg,
      input  iss_ready, busy_vec, outstanding, err_underflow
   );
   modport slave (
      input  flush, iss_valid, iss_src0, iss_src1, iss_dst0, iss_dst1,
             wb0_valid, wb0_reg, wb1_valid, wb1_reg,
      output iss_ready, busy_vec, outstanding, err_underflow
   );
endinterface

// File: rtl/reg_scoreboard_entry.sv
// reg_scoreboard_entry: pending-write counter for one register.
//   inc_i       : one accepted issue targets this register
//   dec_i       : writeback hits from ports 1/0
//   clear_i     : drop all pending writes
//   busy_o/full_o : count nonzero / count at MAX_PENDING
//   underflow_o : more writebacks than pending writes this cycle
//   eff_dec_o   : decrements actually applied after clamping
module reg_scoreboard_entry
   import reg_scoreboard_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inc_i,
   input  logic [1:0] dec_i,
   input  logic       clear_i,
   output logic       busy_o,
   output logic       full_o,
   output logic       underflow_o,
   output logic [1:0] eff_dec_o
);
   pend_cnt_t cnt_q, cnt_d;
   logic [2:0] avail, want;
   // Issue and writeback on the same cycle are netted; decrements beyond
   // what is available clamp the count at zero.
   always_comb begin
      avail = 3'(cnt_q) + 3'(inc_i);
      want = 3'(dec_i[0]) + 3'(dec_i[1]);
      underflow_o = want > avail;
      eff_dec_o = underflow_o ? avail[1:0] : want[1:0];
      cnt_d = clear_i ? '0 : pend_cnt_t'(avail - 3'(eff_dec_o));
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign busy_o = cnt_q != '0;
   assign full_o = cnt_q == pend_cnt_t'(MAX_PENDING);
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks pending register writes and gates issue on hazards.
//   clk, reset_n : clock and asynchronous active-low reset
//   sb           : issue/writeback/status bundle (slave side)
module reg_scoreboard
   import reg_scoreboard_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   reg_scoreboard_if.slave sb
);
   logic [REG_FILE_SIZE-1:0] busy, full, uf, src_hit, dst_hit, w0_hit, w1_hit, inc_v;
   logic [1:0] eff_v [REG_FILE_SIZE];
   logic [7:0] outstanding_q, outstanding_d;
   logic err_q, err_d;
   logic accept;
   assign src_hit = reg_onehot(sb.iss_src0) | reg_onehot(sb.iss_src1);
   assign dst_hit = reg_onehot(sb.iss_dst0) | reg_onehot(sb.iss_dst1);
   // Writebacks during a flush are dropped, so they cannot raise underflow.
   assign w0_hit = sb.wb0_valid && !sb.flush ? reg_onehot(sb.wb0_reg) : '0;
   assign w1_hit = sb.wb1_valid && !sb.flush ? reg_onehot(sb.wb1_reg) : '0;
   assign sb.iss_ready = !sb.flush && !(|(src_hit & busy)) && !(|(dst_hit & full))
                         && ({1'b0, outstanding_q} + 9'd2 <= 9'd255);
   assign accept = sb.iss_valid && sb.iss_ready;
   // OR-ing the two destination one-hots makes dst0==dst1 count once.
   assign inc_v = accept ? dst_hit : '0;
   for (genvar i = 0; i < REG_FILE_SIZE; i++) begin : g_ent
      reg_scoreboard_entry u_ent (
         .clk        (clk),
         .reset_n    (reset_n),
         .inc_i      (inc_v[i]),
         .dec_i      ({w1_hit[i], w0_hit[i]}),
         .clear_i    (sb.flush),
         .busy_o     (busy[i]),
         .full_o     (full[i]),
         .underflow_o(uf[i]),
         .eff_dec_o  (eff_v[i])
      );
   end
   always_comb begin
      outstanding_d = outstanding_q;
      for (int i = 0; i < REG_FILE_SIZE; i++)
         outstanding_d = outstanding_d + 8'(inc_v[i]) - 8'(eff_v[i]);
      outstanding_d = sb.flush ? 8'd0 : outstanding_d;
      err_d = err_q | (|uf);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         outstanding_q <= '0;
         err_q <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         err_q <= err_d;
      end
   assign sb.busy_vec = busy;
   assign sb.outstanding = outstanding_q;
   assign sb.err_underflow = err_q;
endmodule
